// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter and zero-fill sequencer in front of a single-port RW SRAM macro.
// Grants drive the macro the same cycle; read responses are strobed one cycle later.
module sram_port_arbiter #(
  parameter int ADDR_BITS     = 10,
  parameter int DATA_BITS     = 152,
  parameter int MASK_BITS     = 8,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_write,
  input  logic [ADDR_BITS-1:0] req0_addr,
  input  logic [MASK_BITS-1:0] req0_mask,
  input  logic [DATA_BITS-1:0] req0_wdata,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_write,
  input  logic [ADDR_BITS-1:0] req1_addr,
  input  logic [MASK_BITS-1:0] req1_mask,
  input  logic [DATA_BITS-1:0] req1_wdata,
  output logic                 resp0_valid,
  output logic                 resp1_valid,
  output logic [DATA_BITS-1:0] resp_data,
  output logic                 init_done,
  output logic                 mem_en,
  output logic                 mem_wmode,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [MASK_BITS-1:0] mem_wmask,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata
);

  typedef enum logic {INIT, RUN} state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] count;
  logic                 ptr;
  logic                 vld0_p1;
  logic                 vld1_p1;
  logic                 run;
  logic                 gnt0;
  logic                 gnt1;

  // Stage 0: arbitration and macro drive. Reset gates everything so outputs
  // show their reset values while reset is held, whatever the state flops hold.
  always_comb begin
    run        = (state == RUN) && !reset;
    gnt0       = run && req0_valid && (!ptr || !req1_valid);
    gnt1       = run && req1_valid && (ptr || !req0_valid);
    req0_ready = gnt0;
    req1_ready = gnt1;
    init_done  = run;
    mem_en     = 1'b0;
    mem_wmode  = 1'b0;
    mem_addr   = '0;
    mem_wmask  = '0;
    mem_wdata  = '0;
    if (!reset && state == INIT) begin
      mem_en    = 1'b1;
      mem_wmode = 1'b1;
      mem_addr  = count;
      mem_wmask = '1;
    end else if (gnt0) begin
      mem_en    = 1'b1;
      mem_wmode = req0_write;
      mem_addr  = req0_addr;
      mem_wmask = req0_mask;
      mem_wdata = req0_wdata;
    end else if (gnt1) begin
      mem_en    = 1'b1;
      mem_wmode = req1_write;
      mem_addr  = req1_addr;
      mem_wmask = req1_mask;
      mem_wdata = req1_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= (INIT_ON_RESET != 0) ? INIT : RUN;
      count   <= '0;
      ptr     <= 1'b0;
      vld0_p1 <= 1'b0;
      vld1_p1 <= 1'b0;
    end else begin
      vld0_p1 <= gnt0 && !req0_write;
      vld1_p1 <= gnt1 && !req1_write;
      if (gnt0) ptr <= 1'b1;
      else if (gnt1) ptr <= 1'b0;
      if (state == INIT) begin
        count <= count + 1'b1;
        if (count == '1) state <= RUN;
      end
    end
  end

  // Stage 1: macro rdata arrives now; pass it straight through with the strobe.
  assign resp0_valid = vld0_p1;
  assign resp1_valid = vld1_p1;
  assign resp_data   = mem_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a 16-entry behavioural SRAM macro attached.
module tb_sram_port_arbiter;
  localparam int AB = 4;
  localparam int DB = 152;
  localparam int MB = 8;
  localparam int LW = DB / MB;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0_valid, req0_ready, req0_write;
  logic [AB-1:0] req0_addr;
  logic [MB-1:0] req0_mask;
  logic [DB-1:0] req0_wdata;
  logic          req1_valid, req1_ready, req1_write;
  logic [AB-1:0] req1_addr;
  logic [MB-1:0] req1_mask;
  logic [DB-1:0] req1_wdata;
  logic          resp0_valid, resp1_valid, init_done;
  logic [DB-1:0] resp_data;
  logic          mem_en, mem_wmode;
  logic [AB-1:0] mem_addr;
  logic [MB-1:0] mem_wmask;
  logic [DB-1:0] mem_wdata;
  logic [DB-1:0] mem_rdata = '0;
  logic [DB-1:0] mem_arr [16] = '{default: '1};

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [DB-1:0] D5   = {8{19'h5A5AB}};
  localparam logic [DB-1:0] ONES = '1;
  localparam logic [DB-1:0] MSK3 = {{7{19'h7FFFF}}, 19'h00000};

  always #5 clock = ~clock;

  sram_port_arbiter #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .MASK_BITS(MB), .INIT_ON_RESET(1)
  ) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_mask(req0_mask), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_mask(req1_mask), .req1_wdata(req1_wdata),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_data(resp_data),
    .init_done(init_done), .mem_en(mem_en), .mem_wmode(mem_wmode),
    .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Single-port macro: lane-masked write, registered read data.
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_wmode) begin
        for (int l = 0; l < MB; l++)
          if (mem_wmask[l]) mem_arr[mem_addr][l*LW +: LW] <= mem_wdata[l*LW +: LW];
      end else begin
        mem_rdata <= mem_arr[mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [DB-1:0] got, input logic [DB-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clock);
    check({tag, "_rdy0"}, req0_ready, 0);
    check({tag, "_rdy1"}, req1_ready, 0);
    check({tag, "_resp0"}, resp0_valid, 0);
    check({tag, "_resp1"}, resp1_valid, 0);
    check({tag, "_done"}, init_done, 0);
    check({tag, "_en"}, mem_en, 0);
    check({tag, "_wmode"}, mem_wmode, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wmask"}, mem_wmask, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
  endtask

  task automatic check_sweep(input int k);
    @(negedge clock);
    check("sweep_en", mem_en, 1);
    check("sweep_wmode", mem_wmode, 1);
    check("sweep_addr", mem_addr, k);
    check("sweep_wmask", mem_wmask, 8'hFF);
    check("sweep_wdata", mem_wdata, 0);
    check("sweep_rdy0", req0_ready, 0);
    check("sweep_rdy1", req1_ready, 0);
    check("sweep_done", init_done, 0);
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 4'd0; req0_mask = '0; req0_wdata = '0;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 4'd1; req1_mask = '0; req1_wdata = '0;
    next_cycle();
    check_reset_outputs("rst");
    next_cycle();
    reset = 1'b0;

    // zero-fill sweep with both valids held high
    for (int k = 0; k < 16; k++) begin
      check_sweep(k);
      next_cycle();
    end

    // cycle 16: strict alternation under contention, reads of addr 0 / 1
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("cont_done", init_done, 1);
      check("cont_rdy0", req0_ready, (i % 2 == 0) ? 1 : 0);
      check("cont_rdy1", req1_ready, (i % 2 == 1) ? 1 : 0);
      check("cont_en", mem_en, 1);
      check("cont_addr", mem_addr, i % 2);
      if (i > 0) begin
        check("cont_resp0", resp0_valid, (i % 2 == 1) ? 1 : 0);
        check("cont_resp1", resp1_valid, (i % 2 == 0) ? 1 : 0);
        check("cont_rdata", resp_data, 0);
      end
      next_cycle();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clock);
    check("idle_resp1", resp1_valid, 1);
    check("idle_resp0", resp0_valid, 0);
    check("idle_rdata", resp_data, 0);
    check("idle_rdy0", req0_ready, 0);
    check("idle_rdy1", req1_ready, 0);
    check("idle_en", mem_en, 0);
    check("idle_addr", mem_addr, 0);
    next_cycle();

    // pointer follows the loser, holds while idle
    req0_valid = 1'b1; req0_addr = 4'd2;
    @(negedge clock); check("rr_a_rdy0", req0_ready, 1);
    next_cycle();
    req1_valid = 1'b1;
    @(negedge clock); check("rr_b_rdy1", req1_ready, 1); check("rr_b_rdy0", req0_ready, 0);
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clock); check("rr_c_rdy1", req1_ready, 1);
    next_cycle();
    req0_valid = 1'b1;
    @(negedge clock); check("rr_d_rdy0", req0_ready, 1); check("rr_d_rdy1", req1_ready, 0);
    next_cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    next_cycle();
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clock); check("rr_e_rdy1", req1_ready, 1); check("rr_e_rdy0", req0_ready, 0);
    next_cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    next_cycle();

    // write then read addr 5 through req0
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 4'd5; req0_wdata = D5; req0_mask = 8'hFF;
    @(negedge clock);
    check("wr_rdy0", req0_ready, 1);
    check("wr_wmode", mem_wmode, 1);
    check("wr_addr", mem_addr, 5);
    check("wr_wdata", mem_wdata, D5);
    check("wr_wmask", mem_wmask, 8'hFF);
    next_cycle();
    req0_write = 1'b0;
    @(negedge clock);
    check("rd_rdy0", req0_ready, 1);
    check("rd_wmode", mem_wmode, 0);
    check("wr_noresp", resp0_valid, 0);
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clock);
    check("rd_resp0", resp0_valid, 1);
    check("rd_resp1", resp1_valid, 0);
    check("rd_data", resp_data, D5);
    next_cycle();

    // masked write on req1: lane 0 cleared, lanes 1-7 stay ones
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 4'd3; req1_wdata = ONES; req1_mask = 8'hFF;
    next_cycle();
    req1_wdata = '0; req1_mask = 8'h01;
    @(negedge clock); check("mw_wmask", mem_wmask, 8'h01);
    next_cycle();
    req1_write = 1'b0;
    next_cycle();
    req1_valid = 1'b0;
    @(negedge clock);
    check("mw_resp1", resp1_valid, 1);
    check("mw_resp0", resp0_valid, 0);
    check("mw_data", resp_data, MSK3);
    next_cycle();

    // read issued in the cycle reset is high
    req0_valid = 1'b1; req0_addr = 4'd5; reset = 1'b1;
    check_reset_outputs("rstrd");
    next_cycle();
    reset = 1'b0; req0_valid = 1'b0;
    @(negedge clock);
    check("rstrd_resp0", resp0_valid, 0);
    check("rstrd_done", init_done, 0);
    check("rstrd_addr", mem_addr, 0);
    check("rstrd_en", mem_en, 1);
    next_cycle();
    for (int k = 1; k < 7; k++) begin
      check_sweep(k);
      next_cycle();
    end

    // reset at sweep cycle 7 restarts from address 0
    reset = 1'b1;
    @(negedge clock); check("midsw_en", mem_en, 0);
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check_sweep(k);
      next_cycle();
    end
    @(negedge clock);
    check("midsw_done", init_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
